// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter/sequencer for the shared SIF XA register-access bus.
// One transaction in flight: accept -> one-cycle strobe -> optional read wait -> response.
module sif_xa_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 busy,
  output logic [AW-1:0]        xa_addr,
  output logic [DW-1:0]        xa_data_wr,
  output logic                 xa_wr_s,
  output logic                 xa_rd_s,
  input  logic [DW-1:0]        xa_data_rd
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t              state;
  req_t [NREQ-1:0]     reqs;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       win;
  logic [PW-1:0]       owner;
  logic [PW:0]         idx;
  logic [CW-1:0]       cnt;
  logic                any_req;
  logic                accept;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign reqs[g] = {req_wr[g], req_addr[g*AW +: AW], req_wdata[g*DW +: DW]};
  end

  assign any_req = |req_valid;
  assign accept  = !rst && (state == IDLE) && any_req;
  assign busy    = (state != IDLE);

  // Scan from the farthest candidate back toward rr_ptr so the nearest valid one wins.
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (req_valid[idx[PW-1:0]]) win = idx[PW-1:0];
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      xa_addr    <= '0;
      xa_data_wr <= '0;
      xa_wr_s    <= 1'b0;
      xa_rd_s    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      xa_wr_s   <= 1'b0;
      xa_rd_s   <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          owner   <= win;
          rr_ptr  <= (win == LAST) ? '0 : win + 1'b1;
          xa_addr <= reqs[win].addr;
          // Reads leave the write-data bus showing the last written value.
          if (reqs[win].wr) xa_data_wr <= reqs[win].wdata;
          xa_wr_s <= reqs[win].wr;
          xa_rd_s <= !reqs[win].wr;
          state   <= ISSUE;
        end
        ISSUE: begin
          cnt   <= CW'(RD_LAT);
          state <= xa_rd_s ? WAIT_RD : IDLE;
        end
        WAIT_RD: begin
          if (cnt == CW'(1)) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= xa_data_rd;
            state            <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Bench for sif_xa_arbiter: a 2-requester/RD_LAT=1 instance and a 3-requester/RD_LAT=3 instance,
// each with an XA slave model and bus/response scoreboards.
module tb_sif_xa_arbiter;
  typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; } bus_t;
  typedef struct { logic [2:0] vec; logic [15:0] data; } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  // ---------------- instance A: NREQ=2, RD_LAT=1
  logic             a_rst;
  logic [1:0]       a_valid, a_wr, a_ready, a_rsp_valid;
  logic [1:0][15:0] a_addr, a_wdata;
  logic [15:0]      a_rsp_rdata, a_xa_addr, a_xa_data_wr, a_xa_data_rd;
  logic             a_busy, a_wr_s, a_rd_s;

  sif_xa_arbiter #(.NREQ(2), .AW(16), .DW(16), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_wr(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .busy(a_busy), .xa_addr(a_xa_addr), .xa_data_wr(a_xa_data_wr), .xa_wr_s(a_wr_s),
    .xa_rd_s(a_rd_s), .xa_data_rd(a_xa_data_rd));

  // ---------------- instance B: NREQ=3, RD_LAT=3
  logic             b_rst;
  logic [2:0]       b_valid, b_wr, b_ready, b_rsp_valid;
  logic [2:0][15:0] b_addr, b_wdata;
  logic [15:0]      b_rsp_rdata, b_xa_addr, b_xa_data_wr, b_xa_data_rd;
  logic             b_busy, b_wr_s, b_rd_s;

  sif_xa_arbiter #(.NREQ(3), .AW(16), .DW(16), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_wr(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .busy(b_busy), .xa_addr(b_xa_addr), .xa_data_wr(b_xa_data_wr), .xa_wr_s(b_wr_s),
    .xa_rd_s(b_rd_s), .xa_data_rd(b_xa_data_rd));

  // XA slave: read data is valid only in the cycle RD_LAT after the strobe, garbage otherwise.
  logic [1:0] ha = '0;
  logic [3:0] hb = '0;
  always @(negedge clk) begin
    ha = {ha[0], a_rd_s};
    hb = {hb[2:0], b_rd_s};
    a_xa_data_rd = ha[1] ? (a_xa_addr ^ 16'h1214) : 16'hDEAD;
    b_xa_data_rd = hb[3] ? (b_xa_addr ^ 16'h1214) : 16'hDEAD;
  end

  bus_t qa_bus[$], qb_bus[$];
  rsp_t qa_rsp[$], qb_rsp[$];
  bus_t ea, eb;
  rsp_t ra, rb;

  always @(negedge clk) begin
    if (!a_rst) begin
      chk("a_both_strobes", 32'(a_wr_s & a_rd_s), 0);
      if (a_wr_s | a_rd_s) begin
        if (qa_bus.size() == 0) chk("a_bus_unexpected", 32'(qa_bus.size()), 1);
        else begin
          ea = qa_bus.pop_front();
          chk("a_bus_wr", 32'(a_wr_s), 32'(ea.wr));
          chk("a_bus_addr", 32'(a_xa_addr), 32'(ea.addr));
          chk("a_bus_wdata", 32'(a_xa_data_wr), 32'(ea.data));
        end
      end
      if (|a_rsp_valid) begin
        if (qa_rsp.size() == 0) chk("a_rsp_unexpected", 32'(qa_rsp.size()), 1);
        else begin
          ra = qa_rsp.pop_front();
          chk("a_rsp_vec", 32'(a_rsp_valid), 32'(ra.vec));
          chk("a_rsp_data", 32'(a_rsp_rdata), 32'(ra.data));
        end
      end
    end
    if (!b_rst) begin
      chk("b_both_strobes", 32'(b_wr_s & b_rd_s), 0);
      if (b_wr_s | b_rd_s) begin
        if (qb_bus.size() == 0) chk("b_bus_unexpected", 32'(qb_bus.size()), 1);
        else begin
          eb = qb_bus.pop_front();
          chk("b_bus_wr", 32'(b_wr_s), 32'(eb.wr));
          chk("b_bus_addr", 32'(b_xa_addr), 32'(eb.addr));
          chk("b_bus_wdata", 32'(b_xa_data_wr), 32'(eb.data));
        end
      end
      if (|b_rsp_valid) begin
        if (qb_rsp.size() == 0) chk("b_rsp_unexpected", 32'(qb_rsp.size()), 1);
        else begin
          rb = qb_rsp.pop_front();
          chk("b_rsp_vec", 32'(b_rsp_valid), 32'(rb.vec));
          chk("b_rsp_data", 32'(b_rsp_rdata), 32'(rb.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset with both requesters pending: req0 write 0x0010/0xBEEF, req1 read 0x0020.
    a_rst = 1'b1; a_valid = 2'b11; a_wr = 2'b01;
    a_addr = {16'h0020, 16'h0010}; a_wdata = {16'h0000, 16'hBEEF};
    b_rst = 1'b1; b_valid = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
    repeat (3) begin
      nxt; smp;
      chk("rst_ready", 32'(a_ready), 0);
      chk("rst_flags", 32'({a_busy, a_wr_s, a_rd_s, a_rsp_valid}), 0);
      chk("rst_bus", {a_xa_addr, a_xa_data_wr}, 0);
      chk("rst_rdata", 32'(a_rsp_rdata), 0);
    end
    qa_bus.push_back('{1'b1, 16'h0010, 16'hBEEF});
    qa_bus.push_back('{1'b0, 16'h0020, 16'hBEEF});
    qa_rsp.push_back('{3'b010, 16'h1234});

    nxt; a_rst = 1'b0;                       // T
    smp; chk("first_ready", 32'(a_ready), 'b01);
    nxt; a_valid = 2'b10;                    // T+1
    smp; chk("wr_strobe", 32'({a_wr_s, a_rd_s}), 'b10);
    chk("wr_addr", 32'(a_xa_addr), 'h0010);
    chk("wr_data", 32'(a_xa_data_wr), 'hBEEF);
    chk("issue_ready", 32'(a_ready), 0);
    chk("issue_busy", 32'(a_busy), 1);
    nxt;                                     // T+2: idle, req1 accepted
    smp; chk("wr_done_strobe", 32'(a_wr_s), 0);
    chk("wr_done_busy", 32'(a_busy), 0);
    chk("rd_ready", 32'(a_ready), 'b10);
    nxt; a_valid = 2'b00;                    // T+3: read strobe
    smp; chk("rd_strobe", 32'({a_wr_s, a_rd_s}), 'b01);
    chk("rd_addr", 32'(a_xa_addr), 'h0020);
    chk("rd_keeps_wdata", 32'(a_xa_data_wr), 'hBEEF);
    nxt;                                     // T+4: waiting
    smp; chk("rd_wait_rsp", 32'(a_rsp_valid), 0);
    chk("rd_wait_busy", 32'(a_busy), 1);
    nxt;                                     // T+5: response
    smp; chk("rd_rsp_valid", 32'(a_rsp_valid), 'b10);
    chk("rd_rsp_data", 32'(a_rsp_rdata), 'h1234);
    chk("rd_rsp_busy", 32'(a_busy), 0);
    nxt;
    smp; chk("rsp_pulse", 32'(a_rsp_valid), 0);
    chk("rsp_held", 32'(a_rsp_rdata), 'h1234);
    chk("no_req_ready", 32'(a_ready), 0);

    // Fairness: both hold write requests for four arbitrations.
    nxt; a_valid = 2'b11; a_wr = 2'b11;
    a_addr = {16'h0200, 16'h0100}; a_wdata = {16'hB1B1, 16'hA0A0};
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) qa_bus.push_back('{1'b1, 16'h0100, 16'hA0A0});
      else            qa_bus.push_back('{1'b1, 16'h0200, 16'hB1B1});
    end
    for (int k = 0; k < 4; k++) begin
      smp; chk("fair_grant", 32'(a_ready), (k % 2 == 1) ? 'b10 : 'b01);
      nxt; if (k == 3) a_valid = 2'b00;
      smp; chk("fair_strobe", 32'(a_wr_s), 1);
      nxt;
    end
    smp; chk("fair_idle", 32'({a_busy, a_ready}), 0);

    // Instance B: read from req0 (rr_ptr -> 1), then reset during its wait.
    nxt; b_rst = 1'b0;
    nxt; b_valid = 3'b001; b_wr = 3'b000; b_addr[0] = 16'h0300;
    qb_bus.push_back('{1'b0, 16'h0300, 16'h0000});
    smp; chk("b_rd_ready", 32'(b_ready), 'b001);
    nxt; b_valid = 3'b000;                   // S
    smp; chk("b_rd_strobe", 32'(b_rd_s), 1);
    nxt; b_rst = 1'b1;                       // S+1
    smp; chk("b_wait_busy", 32'(b_busy), 1);
    nxt; b_rst = 1'b0;
    smp; chk("b_abort_busy", 32'({b_busy, b_rd_s}), 0);
    chk("b_abort_rdata", 32'(b_rsp_rdata), 0);
    repeat (4) begin
      nxt; smp; chk("b_abort_rsp", 32'(b_rsp_valid), 0);
    end

    // After reset rr_ptr is 0 again: req0 wins over req1.
    nxt; b_valid = 3'b011; b_wr = 3'b011;
    b_addr[0] = 16'h0400; b_wdata[0] = 16'h4444; b_addr[1] = 16'h0401; b_wdata[1] = 16'h5555;
    qb_bus.push_back('{1'b1, 16'h0400, 16'h4444});
    smp; chk("b_post_rst_grant", 32'(b_ready), 'b001);
    nxt; b_valid = 3'b010;
    nxt; qb_bus.push_back('{1'b1, 16'h0401, 16'h5555});
    smp; chk("b_grant1", 32'(b_ready), 'b010);   // rr_ptr -> 2
    nxt; b_valid = 3'b011;
    b_addr[0] = 16'h0600; b_wdata[0] = 16'h6600; b_addr[1] = 16'h0601; b_wdata[1] = 16'h6611;
    nxt; qb_bus.push_back('{1'b1, 16'h0600, 16'h6600});
    smp; chk("b_wrap_grant", 32'(b_ready), 'b001);
    nxt;
    nxt; qb_bus.push_back('{1'b1, 16'h0601, 16'h6611});
    smp; chk("b_wrap_ptr", 32'(b_ready), 'b010);
    nxt; b_valid = 3'b100; b_wr = 3'b000; b_addr[2] = 16'h0700;

    // Read with RD_LAT=3: accept T -> rsp T+5.
    nxt; qb_bus.push_back('{1'b0, 16'h0700, 16'h6611});
    qb_rsp.push_back('{3'b100, 16'h1514});
    smp; chk("b_rd2_ready", 32'(b_ready), 'b100);
    nxt; b_valid = 3'b000;
    smp; chk("b_rd2_strobe", 32'(b_rd_s), 1);
    repeat (3) begin
      nxt; smp; chk("b_rd2_wait", 32'(b_rsp_valid), 0);
    end
    nxt;
    smp; chk("b_rd2_rsp", 32'(b_rsp_valid), 'b100);
    chk("b_rd2_data", 32'(b_rsp_rdata), 'h1514);

    repeat (3) nxt;
    chk("a_bus_left", 32'(qa_bus.size()), 0);
    chk("a_rsp_left", 32'(qa_rsp.size()), 0);
    chk("b_bus_left", 32'(qb_bus.size()), 0);
    chk("b_rsp_left", 32'(qb_rsp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
